logic_gate_checker: RTL



---
 rtl/logic_gate_pkg.sv | 39 +++
 rtl/logic_gate_checker_ref.sv | 16 +
 rtl/logic_gate_checker.sv | 117 +++++++++++
 3 files changed

// File: rtl/logic_gate_pkg.sv
// Shared types, constants and golden gate truth for the logic_gate checker.
// Bit order of the gate vector: [0]and [1]or [2]not_a [3]nand [4]nor [5]xor [6]xnor.
package logic_gate_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int NUM_VEC   = 4;
    localparam int NUM_GATES = 7;

    localparam int G_AND   = 0;
    localparam int G_OR    = 1;
    localparam int G_NOT_A = 2;
    localparam int G_NAND  = 3;
    localparam int G_NOR   = 4;
    localparam int G_XOR   = 5;
    localparam int G_XNOR  = 6;

    function automatic logic [NUM_GATES-1:0] gate_expected(
        input logic a,
        input logic b
    );
        logic [NUM_GATES-1:0] e;
        e          = '0;
        e[G_AND]   = a & b;
        e[G_OR]    = a | b;
        e[G_NOT_A] = ~a;
        e[G_NAND]  = ~(a & b);
        e[G_NOR]   = ~(a | b);
        e[G_XOR]   = a ^ b;
        e[G_XNOR]  = ~(a ^ b);
        return e;
    endfunction

endpackage

// File: rtl/logic_gate_checker_ref.sv
// Combinational golden model of the two-input gate block.
// Maps the applied vector {a,b} to the seven expected gate outputs.
module logic_gate_ref
    import logic_gate_pkg::*;
(
    input  logic                 a,
    input  logic                 b,
    output logic [NUM_GATES-1:0] y
);

    // Golden truth for every gate at the current vector
    always_comb begin
        y = gate_expected(a, b);
    end

endmodule

// File: rtl/logic_gate_checker.sv
// On-board stimulus/checker: walks {a,b} through 00..11, samples y after a dwell.
// Optional LGC_FAULT_INJECT_EN adds an inject input that corrupts the AND expectation.
module logic_gate_checker
    import logic_gate_pkg::*;
#(
    parameter int DWELL_CYCLES = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 a,
    output logic                 b,
    input  logic [NUM_GATES-1:0] y,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [NUM_GATES-1:0] err_mask,
    output logic [1:0]           first_err_vec,
    output logic [1:0]           vec_idx
`ifdef LGC_FAULT_INJECT_EN
    ,
    input  logic                 inject
`endif
);

    localparam int CNT_W = (DWELL_CYCLES > 0) ? $clog2(DWELL_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [1:0] VEC_LAST = 2'(NUM_VEC - 1);

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [NUM_GATES-1:0] golden;
    logic [NUM_GATES-1:0] expected;
    logic [NUM_GATES-1:0] mism;
    logic [NUM_GATES-1:0] err_next;
    logic [1:0]           vec_next;

    logic_gate_ref u_ref (
        .a (vec_idx[1]),
        .b (vec_idx[0]),
        .y (golden)
    );

    // Expected outputs for the current vector and the resulting mismatch set
    always_comb begin
        expected = golden;
`ifdef LGC_FAULT_INJECT_EN
        if (inject && (state == CHECK)) begin
            expected[G_AND] = ~golden[G_AND];
        end
`endif
        mism     = y ^ expected;
        err_next = err_mask | mism;
        vec_next = vec_idx + 2'd1;
    end

    // Run sequencer: apply each vector for the dwell, check it, then advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            vec_idx       <= '0;
            a             <= 1'b0;
            b             <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_mask      <= '0;
            first_err_vec <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state         <= APPLY;
                        cnt           <= '0;
                        vec_idx       <= '0;
                        a             <= 1'b0;
                        b             <= 1'b0;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        pass          <= 1'b0;
                        err_mask      <= '0;
                        first_err_vec <= '0;
                    end
                end
                APPLY: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    err_mask <= err_next;
                    if ((err_mask == '0) && (mism != '0)) begin
                        first_err_vec <= vec_idx;
                    end
                    if (vec_idx == VEC_LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == '0);
                    end else begin
                        state   <= APPLY;
                        cnt     <= '0;
                        vec_idx <= vec_next;
                        a       <= vec_next[1];
                        b       <= vec_next[0];
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
